// File: rtl/cam_frame_writer.sv
`timescale 1ns/1ps
// Decimates a 640x480 RGB565 stream 4:1 in each axis, mirrors/offsets the
// coordinates for the display path and writes a 160x120 frame buffer.
module cam_frame_writer #(
    parameter int unsigned X_BASE   = 150,
    parameter int unsigned Y_BASE   = 119,
    parameter int unsigned Y_OFFSET = 31,
    parameter int unsigned DST_W    = 160,
    parameter int unsigned DST_H    = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        pixel_valid,
    input  logic [15:0] pixel_data,
    input  logic        line_end,
    input  logic        frame_done,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic [7:0]  frame_count,
    output logic        drop
);

    localparam int unsigned COL_W  = 10;
    localparam int unsigned ROW_W  = 9;
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FC_W   = 8;

    localparam logic [COL_W-1:0] COL_MAX  = '1;
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;
    localparam logic [X_W-1:0]   X_BASE_L = X_BASE[X_W-1:0];
    // Mirror base and offset fold into one constant modulo 128.
    localparam logic [Y_W-1:0]   Y_SUM_L  = Y_W'(Y_BASE + Y_OFFSET);
    localparam logic [X_W:0]     DST_W_L  = DST_W[X_W:0];
    localparam logic [Y_W:0]     DST_H_L  = DST_H[Y_W:0];
    localparam logic [ADDR_W-1:0] STRIDE  = DST_W[ADDR_W-1:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [COL_W-1:0]  col, col_next;
    logic [ROW_W-1:0]  row, row_next;
    logic [FC_W-1:0]   fc_next;

    logic              keep_c;
    logic [X_W-1:0]    x_c;
    logic [Y_W-1:0]    y_c;

    logic              s1_keep;
    logic [X_W-1:0]    s1_x;
    logic [Y_W-1:0]    s1_y;
    logic [DATA_W-1:0] s1_data;

    logic              in_win_c;
    logic [ADDR_W-1:0] addr_c;

    // State and counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            col         <= col_next;
            row         <= row_next;
            frame_count <= fc_next;
            busy        <= (state_next != IDLE);
        end
    end

    // Next-state and counter update; frame_done outranks line_end
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        fc_next    = frame_count;
        case (state)
            IDLE: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (frame_done) begin
                    col_next   = '0;
                    row_next   = '0;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (frame_done) begin
                    col_next   = '0;
                    row_next   = '0;
                    fc_next    = frame_count + FC_W'(1);
                    state_next = enable ? CAPTURE : IDLE;
                end else if (line_end) begin
                    col_next = '0;
                    if (row != ROW_MAX) row_next = row + ROW_W'(1);
                end else if (pixel_valid) begin
                    if (col != COL_MAX) col_next = col + COL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: keep qualifier and mirrored coordinates from pre-update counters
    always_comb begin
        keep_c = pixel_valid && (state == CAPTURE) && (col[1:0] == 2'b00) && (row[1:0] == 2'b00);
        x_c    = X_BASE_L - col[COL_W-1:2];
        y_c    = Y_SUM_L - row[ROW_W-1:2];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_keep <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_data <= '0;
        end else begin
            s1_keep <= keep_c;
            s1_x    <= x_c;
            s1_y    <= y_c;
            s1_data <= pixel_data;
        end
    end

    // Stage 2: window check, address and write strobe
    always_comb begin
        in_win_c = ({1'b0, s1_x} < DST_W_L) && ({1'b0, s1_y} < DST_H_L);
        addr_c   = ADDR_W'(s1_y) * STRIDE + ADDR_W'(s1_x);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en   <= 1'b0;
            drop    <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= s1_keep && in_win_c;
            drop  <= s1_keep && !in_win_c;
            if (s1_keep && in_win_c) begin
                wr_addr <= addr_c;
                wr_data <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
`timescale 1ns/1ps
// Directed bench for cam_frame_writer: arming, decimation, windowing,
// vertical wrap, coincident strobes, enable release and async reset.
module tb_cam_frame_writer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic        line_end;
    logic        frame_done;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic [7:0]  frame_count;
    logic        drop;

    int tests = 0;
    int fails = 0;
    int drops = 0;
    int q_addr[$];
    int q_data[$];

    cam_frame_writer dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .line_end    (line_end),
        .frame_done  (frame_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_count (frame_count),
        .drop        (drop)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and log every write/drop seen after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            q_addr.push_back(int'(wr_addr));
            q_data.push_back(int'(wr_data));
        end
        if (drop === 1'b1) drops++;
    endtask

    task automatic clrlog();
        q_addr.delete();
        q_data.delete();
        drops = 0;
    endtask

    task automatic feed(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = base + 16'(i);
            tick();
        end
        pixel_valid = 1'b0;
    endtask

    task automatic lend(input int n);
        for (int i = 0; i < n; i++) begin
            line_end = 1'b1;
            tick();
            line_end = 1'b0;
        end
    endtask

    task automatic fdone();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic drain();
        tick();
        tick();
    endtask

    function automatic int qa0();
        return (q_addr.size() > 0) ? q_addr[0] : -1;
    endfunction

    function automatic int qd0();
        return (q_data.size() > 0) ? q_data[0] : -1;
    endfunction

    initial begin
        resetn      = 1'b0;
        enable      = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        line_end    = 1'b0;
        frame_done  = 1'b0;
        #5;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_drop", 32'(drop), 0);
        tick();
        resetn = 1'b1;
        tick();

        // Arm; pixels before the first frame_done are ignored
        enable = 1'b1;
        tick();
        chk("arm_busy", 32'(busy), 1);
        clrlog();
        feed(8, 16'h0100);
        drain();
        chk("arm_no_writes", 32'(q_addr.size()), 0);
        chk("arm_no_drops", 32'(drops), 0);
        fdone();
        chk("capture_busy", 32'(busy), 1);

        // First pixel: exact two-cycle latency
        clrlog();
        pixel_valid = 1'b1;
        pixel_data  = 16'h1234;
        tick();
        pixel_valid = 1'b0;
        chk("lat_n1_wr_en", 32'(wr_en), 0);
        tick();
        chk("lat_n2_wr_en", 32'(wr_en), 1);
        chk("lat_n2_addr", 32'(wr_addr), 3670);
        chk("lat_n2_data", 32'(wr_data), 32'h1234);
        tick();
        chk("lat_n3_wr_en", 32'(wr_en), 0);
        chk("hold_addr", 32'(wr_addr), 3670);
        chk("hold_data", 32'(wr_data), 32'h1234);

        // Remaining cols 1..7: only col 4 is kept
        clrlog();
        feed(7, 16'h2001);
        drain();
        chk("dec_count", 32'(q_addr.size()), 1);
        chk("dec_addr", 32'(qa0()), 3669);
        chk("dec_data", 32'(qd0()), 32'h2004);

        // Col 604 mirrors to x=255: drop, no write
        feed(596, 16'h0008);
        drain();
        clrlog();
        feed(1, 16'hDDDD);
        drain();
        chk("col604_drop", 32'(drops), 1);
        chk("col604_no_write", 32'(q_addr.size()), 0);
        feed(35, 16'h0000);
        lend(1);

        // Row 1: nothing kept
        clrlog();
        feed(640, 16'h0000);
        drain();
        chk("row1_no_writes", 32'(q_addr.size()), 0);
        chk("row1_no_drops", 32'(drops), 0);
        lend(1);

        // Row 88 -> y=0
        lend(86);
        clrlog();
        feed(1, 16'hA088);
        drain();
        chk("row88_count", 32'(q_addr.size()), 1);
        chk("row88_addr", 32'(qa0()), 150);
        chk("row88_data", 32'(qd0()), 32'hA088);

        // Row 92 -> y=127, outside window
        lend(4);
        clrlog();
        feed(1, 16'hA092);
        drain();
        chk("row92_drop", 32'(drops), 1);
        chk("row92_no_write", 32'(q_addr.size()), 0);

        // Row 124 -> y=119
        lend(32);
        clrlog();
        feed(1, 16'hA124);
        drain();
        chk("row124_addr", 32'(qa0()), 19190);
        chk("row124_data", 32'(qd0()), 32'hA124);

        // pixel_valid with line_end at col 8, row 128: uses col 8
        lend(4);
        feed(8, 16'h3000);
        drain();
        clrlog();
        pixel_valid = 1'b1;
        line_end    = 1'b1;
        pixel_data  = 16'hBEEF;
        tick();
        pixel_valid = 1'b0;
        line_end    = 1'b0;
        drain();
        chk("pvle_count", 32'(q_addr.size()), 1);
        chk("pvle_addr", 32'(qa0()), 19028);
        chk("pvle_data", 32'(qd0()), 32'hBEEF);

        // Same coincidence on row 131 must leave col 0 for row 132
        lend(2);
        feed(8, 16'h0000);
        pixel_valid = 1'b1;
        line_end    = 1'b1;
        pixel_data  = 16'h1111;
        tick();
        pixel_valid = 1'b0;
        line_end    = 1'b0;
        clrlog();
        feed(1, 16'hC0DE);
        drain();
        chk("pvle_col_clear_addr", 32'(qa0()), 18870);
        chk("pvle_col_clear_data", 32'(qd0()), 32'hC0DE);

        // frame_done with line_end: row back to 0, one frame counted
        frame_done = 1'b1;
        line_end   = 1'b1;
        tick();
        frame_done = 1'b0;
        line_end   = 1'b0;
        chk("fdle_frame_count", 32'(frame_count), 1);
        clrlog();
        feed(1, 16'h5555);
        drain();
        chk("fdle_row0_addr", 32'(qa0()), 3670);
        chk("fdle_row0_data", 32'(qd0()), 32'h5555);

        // Enable released at row 200: frame completes, then IDLE
        lend(200);
        enable = 1'b0;
        tick();
        chk("endrop_busy_held", 32'(busy), 1);
        clrlog();
        feed(1, 16'h6666);
        drain();
        chk("endrop_addr", 32'(qa0()), 16150);
        chk("endrop_data", 32'(qd0()), 32'h6666);
        lend(1);
        fdone();
        chk("endrop_busy_low", 32'(busy), 0);
        chk("endrop_frame_count", 32'(frame_count), 2);
        clrlog();
        feed(4, 16'h7777);
        drain();
        fdone();
        chk("idle_no_writes", 32'(q_addr.size()), 0);
        chk("idle_frame_count", 32'(frame_count), 2);

        // Async reset between pixel_valid and its write
        enable = 1'b1;
        tick();
        fdone();
        clrlog();
        pixel_valid = 1'b1;
        pixel_data  = 16'h9999;
        tick();
        pixel_valid = 1'b0;
        #5;
        resetn = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_wr_addr", 32'(wr_addr), 0);
        chk("arst_wr_data", 32'(wr_data), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_frame_count", 32'(frame_count), 0);
        chk("arst_drop", 32'(drop), 0);
        tick();
        tick();
        chk("arst_no_write", 32'(q_addr.size()), 0);
        resetn = 1'b1;
        drain();
        chk("arst_after_release", 32'(q_addr.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Sits between the camera pixel assembler and the 160x120 RGB565 frame buffer. Takes the 640x480 pixel stream (`pixel_valid` / `pixel_data`, line and frame markers) and keeps one pixel in every 4x4 block. It applies the horizontal mirror and the vertical offset used by the display path. It issues buffer writes `wr_en`, `wr_addr` = y*160+x and `wr_data`, frame-aligned, with a fixed two-cycle pipeline.

## Interface
Parameters:
- `X_BASE`, 150: horizontal mirror base; x = X_BASE - col/4.
- `Y_BASE`, 119: vertical mirror base.
- `Y_OFFSET`, 31: vertical alignment offset added after mirroring.
- `DST_W`, 160: buffer width; also the address row stride.
- `DST_H`, 120: buffer height.

Ports:
- `clk` input 1: 25 MHz system clock; every register is on its rising edge.
- `resetn` input 1: asynchronous active-low reset.
- `enable` input 1: level; request capture.
- `pixel_valid` input 1: one-cycle strobe; `pixel_data` is valid on this cycle.
- `pixel_data` input 16: RGB565 pixel.
- `line_end` input 1: one-cycle strobe at the end of each source line.
- `frame_done` input 1: one-cycle strobe at the end of each source frame.
- `wr_en` output 1: buffer write strobe.
- `wr_addr` output 15: buffer write address.
- `wr_data` output 16: buffer write data.
- `busy` output 1: high in ARM or CAPTURE.
- `frame_count` output 8: number of completed captured frames; wraps.
- `drop` output 1: one-cycle pulse for a kept pixel that falls outside the buffer window.

## Operation
- Reset state, applied immediately on `resetn` low: state IDLE, col=0, row=0, pipeline cleared. `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `frame_count`=0, `drop`=0.
- State IDLE → ARM when `enable`=1.
- State ARM: waits for the first `frame_done`, so capture never starts mid-frame. On `frame_done`: clear counters, go to CAPTURE. `enable`=0 while in ARM → IDLE.
- State CAPTURE:
  - col: 10-bit, incremented on each `pixel_valid`, saturates at 1023.
  - row: 9-bit, incremented on `line_end`, saturates at 511.
  - `line_end` clears col.
- Frame end in CAPTURE (`frame_done`):
  - col=0, row=0, `frame_count` +1 (255 wraps to 0).
  - If `enable`=0, go to IDLE; otherwise stay in CAPTURE.
  - `enable` dropping mid-frame never aborts the frame.
- Keep rule: a pixel is kept when col[1:0]==0 and row[1:0]==0.
- Coordinates:
  - x = (X_BASE - col[9:2]) mod 256, 8 bits.
  - y = (Y_BASE - row[8:2] + Y_OFFSET) mod 128, 7 bits.
- Window: a kept pixel is written when x<DST_W and y<DST_H. Otherwise it produces a `drop` pulse and no write.
- Address: `wr_addr` = (y<<7)+(y<<5)+x, 15 bits, no overflow for in-window values.
- Simultaneous `pixel_valid` and `line_end`: the pixel uses the pre-clear col and row. col is then cleared.
- Simultaneous `pixel_valid` and `frame_done`: the pixel is processed with the old counters, then the counters clear.
- Simultaneous `line_end` and `frame_done`: `frame_done` wins; row=0.
- Strobes arriving in IDLE or ARM cause no writes and no counter changes.
- Pipeline drains after a state change: a pixel accepted in CAPTURE still produces its write or drop even if the state leaves CAPTURE.

## Timing
- Stage 1, cycle N+1: register the keep qualifier, x, y and data for a `pixel_valid` sampled at edge N.
- Stage 2, cycle N+2: `wr_en`, `wr_addr`, `wr_data` are registered; `wr_en` is high for exactly one cycle. `drop` is also asserted at N+2.
- Throughput: one pixel per cycle; back-to-back `pixel_valid` is accepted with no stall.
- `wr_addr` and `wr_data` hold their last value while `wr_en`=0.
- `busy` and `frame_count` update one cycle after the qualifying edge.

## Test plan
- Reset and alignment: reset, `enable`=1, pixels before the first `frame_done` → no `wr_en`, `busy`=1. After `frame_done`, the pixel at col 0 row 0 → at N+2 `wr_en`=1, x=150, y=22, `wr_addr`=3670, data echoed.
- Decimation and window:
  - Pixels col 0..7 on row 0 → writes only at col 0 (addr 3670) and col 4 (addr 3669).
  - Col 604 (x=255) → `drop` pulse, no write.
  - Row 1 → no writes.
- Vertical wrap: row 88 (row/4=22), col 0 → y=0, `wr_addr`=150. Row 92 → y=127 → `drop`. Row 124 → y=119, `wr_addr`=19190.
- Simultaneous events: `pixel_valid`+`line_end` at col 8 → write uses col 8 (x=148), then the next pixel has col 0. `frame_done` with `line_end` → row resets to 0, `frame_count`=1.
- Enable drop mid-frame: `enable`=0 at row 200 → writes continue to `frame_done`, then IDLE, `busy`=0, `frame_count` increments once.
- Async reset mid-pipeline: `resetn` low between `pixel_valid` and N+2 → no `wr_en`. All outputs zero immediately, without waiting for a clock edge.
